// File: rtl/cmos_power_seq_ctrl.sv
// OV5640 power-up / configuration sequencer.
// Walks the sensor through PWDN and RESETB with millisecond timing, then releases
// the I2C register-write engine and waits for its config-done flag. A timeout
// triggers a full power cycle, and the sequencer parks the sensor in FAIL after
// MAX_RETRY timed-out attempts.
module cmos_power_seq_ctrl #(
    parameter int unsigned CLK_FREQ       = 100_000_000,
    parameter int unsigned PWDN_DELAY_MS  = 5,
    parameter int unsigned RESET_DELAY_MS = 1,
    parameter int unsigned SCCB_DELAY_MS  = 20,
    parameter int unsigned CFG_TIMEOUT_MS = 500,
    parameter int unsigned CFG_GUARD      = 16,
    parameter int unsigned MAX_RETRY      = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       reinit_req,
    input  logic       cfg_done,
    output logic       cmos_pwdn,
    output logic       cmos_rst_n,
    output logic       cfg_rst_n,
    output logic       init_done,
    output logic       init_fail,
    output logic [3:0] retry_cnt,
    output logic [2:0] seq_state
);

    localparam int unsigned DIV        = CLK_FREQ / 1000;
    localparam logic [16:0] PRESC_LAST = 17'(DIV - 1);
    localparam logic [9:0]  PWDN_LAST  = 10'(PWDN_DELAY_MS - 1);
    localparam logic [9:0]  RESET_LAST = 10'(RESET_DELAY_MS - 1);
    localparam logic [9:0]  SCCB_LAST  = 10'(SCCB_DELAY_MS - 1);
    localparam logic [9:0]  CFG_LAST   = 10'(CFG_TIMEOUT_MS - 1);
    localparam logic [7:0]  GUARD_LEN  = 8'(CFG_GUARD);
    localparam logic [3:0]  RETRY_MAX  = 4'(MAX_RETRY);

    localparam logic [2:0] S_PWDN_HOLD = 3'd0;
    localparam logic [2:0] S_PWR_UP    = 3'd1;
    localparam logic [2:0] S_RST_REL   = 3'd2;
    localparam logic [2:0] S_CONFIG    = 3'd3;
    localparam logic [2:0] S_READY     = 3'd4;
    localparam logic [2:0] S_FAIL      = 3'd5;

    logic [2:0]  state_q;
    logic [2:0]  state_d;
    logic [16:0] presc_q;
    logic [9:0]  ms_q;
    logic [7:0]  guard_q;
    logic        ms_wrap;
    logic        pwdn_elapsed;
    logic        reset_elapsed;
    logic        sccb_elapsed;
    logic        cfg_timeout;
    logic        guard_over;
    logic        cfg_ok;
    logic        state_change;
    logic        reinit_ok;
    logic [3:0]  retry_next;

    // The last cycle of an N ms state is the prescaler wrap that would make ms_cnt reach N.
    assign ms_wrap       = (presc_q == PRESC_LAST);
    assign pwdn_elapsed  = ms_wrap && (ms_q == PWDN_LAST);
    assign reset_elapsed = ms_wrap && (ms_q == RESET_LAST);
    assign sccb_elapsed  = ms_wrap && (ms_q == SCCB_LAST);
    assign cfg_timeout   = ms_wrap && (ms_q == CFG_LAST);
    assign guard_over    = (guard_q == GUARD_LEN);
    assign cfg_ok        = guard_over && cfg_done;
    assign retry_next    = retry_cnt + 4'd1;
    assign state_change  = (state_d != state_q);
    assign reinit_ok     = reinit_req && ((state_q == S_READY) || (state_q == S_FAIL));
    assign seq_state     = state_q;

    // Next-state selection; cfg_done takes priority over a coincident timeout.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_PWDN_HOLD: if (pwdn_elapsed)  state_d = S_PWR_UP;
            S_PWR_UP:    if (reset_elapsed) state_d = S_RST_REL;
            S_RST_REL:   if (sccb_elapsed)  state_d = S_CONFIG;
            S_CONFIG: begin
                if (cfg_ok)
                    state_d = S_READY;
                else if (cfg_timeout)
                    state_d = (retry_next >= RETRY_MAX) ? S_FAIL : S_PWDN_HOLD;
            end
            S_READY, S_FAIL: if (reinit_req) state_d = S_PWDN_HOLD;
            default:     state_d = S_PWDN_HOLD;
        endcase
    end

    // Millisecond timebase, restarted on every state entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q <= '0;
            ms_q    <= '0;
        end else if (state_change) begin
            presc_q <= '0;
            ms_q    <= '0;
        end else if (ms_wrap) begin
            presc_q <= '0;
            ms_q    <= ms_q + 10'd1;
        end else begin
            presc_q <= presc_q + 17'd1;
        end
    end

    // Guard window after engine release, during which a stale cfg_done is ignored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            guard_q <= '0;
        else if (state_change)
            guard_q <= '0;
        else if ((state_q == S_CONFIG) && !guard_over)
            guard_q <= guard_q + 8'd1;
    end

    // State register with pin outputs registered from the incoming state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_PWDN_HOLD;
            cmos_pwdn  <= 1'b1;
            cmos_rst_n <= 1'b0;
            cfg_rst_n  <= 1'b0;
            init_done  <= 1'b0;
            init_fail  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cmos_pwdn  <= (state_d == S_PWDN_HOLD) || (state_d == S_FAIL);
            cmos_rst_n <= (state_d == S_RST_REL) || (state_d == S_CONFIG) || (state_d == S_READY);
            cfg_rst_n  <= (state_d == S_CONFIG) || (state_d == S_READY);
            init_done  <= (state_d == S_READY);
            init_fail  <= (state_d == S_FAIL);
        end
    end

    // Failed-attempt counter: bumps on timeout, saturates, cleared only by reinit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            retry_cnt <= '0;
        else if (reinit_ok)
            retry_cnt <= '0;
        else if ((state_q == S_CONFIG) && !cfg_ok && cfg_timeout && (retry_cnt != RETRY_MAX))
            retry_cnt <= retry_next;
    end

endmodule

// File: tb/tb_cmos_power_seq_ctrl.sv
// Bench for cmos_power_seq_ctrl at CLK_FREQ=10_000 (10 cycles per ms).
// Stimulus tasks push expected output transitions (edge number + pin/state vector)
// computed from phase durations; a monitor pops one entry whenever the DUT outputs change.
module tb_cmos_power_seq_ctrl;

    localparam int unsigned CLK_FREQ    = 10_000;
    localparam int unsigned DIV         = CLK_FREQ / 1000;
    localparam int unsigned PWDN_CYC    = 5 * DIV;
    localparam int unsigned RESET_CYC   = 1 * DIV;
    localparam int unsigned SCCB_CYC    = 20 * DIV;
    localparam int unsigned TIMEOUT_CYC = 500 * DIV;
    localparam int unsigned GUARD       = 16;
    localparam int unsigned MAX_RETRY   = 3;
    localparam int unsigned NEVER       = 1_000_000;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       reinit_req = 1'b0;
    logic       cfg_done = 1'b0;
    logic       cmos_pwdn;
    logic       cmos_rst_n;
    logic       cfg_rst_n;
    logic       init_done;
    logic       init_fail;
    logic [3:0] retry_cnt;
    logic [2:0] seq_state;

    cmos_power_seq_ctrl #(
        .CLK_FREQ       (CLK_FREQ),
        .PWDN_DELAY_MS  (5),
        .RESET_DELAY_MS (1),
        .SCCB_DELAY_MS  (20),
        .CFG_TIMEOUT_MS (500),
        .CFG_GUARD      (GUARD),
        .MAX_RETRY      (MAX_RETRY)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .reinit_req (reinit_req),
        .cfg_done   (cfg_done),
        .cmos_pwdn  (cmos_pwdn),
        .cmos_rst_n (cmos_rst_n),
        .cfg_rst_n  (cfg_rst_n),
        .init_done  (init_done),
        .init_fail  (init_fail),
        .retry_cnt  (retry_cnt),
        .seq_state  (seq_state)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned t;
        logic [11:0] v;
    } ev_t;

    ev_t         exp_q[$];
    int          errors = 0;
    int          checks = 0;
    int unsigned cyc = 0;
    int unsigned base = 0;
    logic        mon_en = 1'b0;
    logic [11:0] prev;
    logic [11:0] outvec;
    logic [11:0] cur;
    ev_t         got_ev;

    // engine model state
    int unsigned eng_d0 = NEVER;
    int unsigned eng_d1 = NEVER;
    int unsigned eng_cnt = 0;
    int unsigned eng_att = 0;
    int unsigned eng_cur_d;
    bit          eng_on = 1'b0;
    bit          eng_tied1 = 1'b0;

    assign outvec = {cmos_pwdn, cmos_rst_n, cfg_rst_n, init_done, init_fail, retry_cnt, seq_state};

    always @(posedge clk) cyc = cyc + 1;

    function automatic int unsigned now();
        return cyc - base;
    endfunction

    function automatic logic [11:0] mk(input bit p, input bit r, input bit c, input bit dn,
                                       input bit f, input int unsigned rc, input int unsigned st);
        return {p, r, c, dn, f, 4'(rc), 3'(st)};
    endfunction

    // I2C engine model: cfg_done rises eng_d cycles after each cfg_rst_n release.
    always @(posedge clk) begin
        #1;
        if (!cfg_rst_n) begin
            eng_on = 1'b0;
        end else if (!eng_on) begin
            eng_on  = 1'b1;
            eng_cnt = 0;
            eng_att = eng_att + 1;
        end else begin
            eng_cnt = eng_cnt + 1;
        end
        eng_cur_d = (eng_att <= 1) ? eng_d0 : eng_d1;
        cfg_done  = eng_tied1 ? 1'b1 : (cfg_rst_n && eng_on && (eng_cnt >= eng_cur_d));
    end

    // Monitor: every change of the output vector must match the next expected event.
    always @(negedge clk) begin
        if (mon_en) begin
            cur = outvec;
            if (cur !== prev) begin
                checks = checks + 1;
                if (exp_q.size() == 0) begin
                    errors = errors + 1;
                    $display("FAIL unexpected_change at edge %0d: got=%h, none expected", now(), cur);
                end else begin
                    got_ev = exp_q.pop_front();
                    if ((got_ev.t != now()) || (got_ev.v !== cur)) begin
                        errors = errors + 1;
                        $display("FAIL event: got edge %0d vec=%h, required edge %0d vec=%h",
                                 now(), cur, got_ev.t, got_ev.v);
                    end
                end
                prev = cur;
            end
        end
    end

    task automatic push(input int unsigned t, input logic [11:0] v);
        ev_t e;
        e.t = t;
        e.v = v;
        exp_q.push_back(e);
    endtask

    // Reference: expected transitions of one full sequence starting in PWDN_HOLD at edge t0.
    task automatic gen_seq(input int unsigned t0, input int unsigned r0);
        int unsigned t = t0;
        int unsigned r = r0;
        int unsigned a = 0;
        int unsigned d, t_cfg, t_acc, t_to, acc_off;
        forever begin
            d = (a == 0) ? eng_d0 : eng_d1;
            push(t + PWDN_CYC, mk(0, 0, 0, 0, 0, r, 1));
            push(t + PWDN_CYC + RESET_CYC, mk(0, 1, 0, 0, 0, r, 2));
            t_cfg = t + PWDN_CYC + RESET_CYC + SCCB_CYC;
            push(t_cfg, mk(0, 1, 1, 0, 0, r, 3));
            acc_off = eng_tied1 ? GUARD + 1 : ((d + 1 > GUARD + 1) ? d + 1 : GUARD + 1);
            t_acc = t_cfg + acc_off;
            t_to  = t_cfg + TIMEOUT_CYC;
            if (t_acc <= t_to) begin
                push(t_acc, mk(0, 1, 1, 1, 0, r, 4));
                return;
            end
            r = r + 1;
            if (r == MAX_RETRY) begin
                push(t_to, mk(1, 0, 0, 0, 1, r, 5));
                return;
            end
            push(t_to, mk(1, 0, 0, 0, 0, r, 0));
            t = t_to;
            a = a + 1;
        end
    endtask

    task automatic check_vec(input string name, input logic [11:0] req);
        checks = checks + 1;
        if (outvec !== req) begin
            errors = errors + 1;
            $display("FAIL %s: got=%h required=%h", name, outvec, req);
        end
    endtask

    task automatic tick_to(input int unsigned n);
        while (now() < n) @(negedge clk);
    endtask

    task automatic pulse_reinit();
        reinit_req = 1'b1;
        @(negedge clk);
        reinit_req = 1'b0;
    endtask

    task automatic start_run(input int unsigned d0, input int unsigned d1, input bit tied);
        @(negedge clk);
        mon_en     = 1'b0;
        rst_n      = 1'b0;
        reinit_req = 1'b0;
        eng_d0     = d0;
        eng_d1     = d1;
        eng_tied1  = tied;
        eng_att    = 0;
        repeat (2) @(negedge clk);
        check_vec("reset_state", mk(1, 0, 0, 0, 0, 0, 0));
        exp_q.delete();
        prev  = mk(1, 0, 0, 0, 0, 0, 0);
        rst_n = 1'b1;
        base  = cyc;
        gen_seq(0, 0);
        mon_en = 1'b1;
    endtask

    task automatic reinit_from_idle();
        int unsigned e;
        e = now() + 1;
        push(e, mk(1, 0, 0, 0, 0, 0, 0));
        gen_seq(e, 0);
        pulse_reinit();
    endtask

    task automatic drain(input int unsigned quiet);
        int unsigned lim;
        lim = now() + 20000;
        while ((exp_q.size() != 0) && (now() < lim)) @(negedge clk);
        checks = checks + 1;
        if (exp_q.size() != 0) begin
            errors = errors + 1;
            $display("FAIL drain: %0d expected events still pending at edge %0d, required 0",
                     exp_q.size(), now());
            exp_q.delete();
        end
        repeat (quiet) @(negedge clk);
    endtask

    initial begin
        int unsigned d;
        int unsigned pe;
        int unsigned gd[3];
        gd[0] = 15;
        gd[1] = 16;
        gd[2] = 17;

        // nominal, with a request during RST_REL that must be ignored
        start_run(300, 300, 1'b0);
        tick_to(99);
        pulse_reinit();
        drain(50);
        // reinit from READY repeats the same timing
        reinit_from_idle();
        drain(50);

        // stale cfg_done held high
        start_run(0, 0, 1'b1);
        drain(50);

        // guard window edges
        for (int i = 0; i < 3; i++) begin
            start_run(gd[i], gd[i], 1'b0);
            drain(20);
        end

        // cfg_done on the timeout cycle wins
        start_run(TIMEOUT_CYC - 1, TIMEOUT_CYC - 1, 1'b0);
        drain(50);

        // one timeout then success: retry_cnt stays 1 in READY, cleared by reinit
        start_run(NEVER, 120, 1'b0);
        drain(50);
        eng_d0 = 120;
        reinit_from_idle();
        drain(50);

        // no acknowledge at all: three power cycles, then parked in FAIL
        start_run(NEVER, NEVER, 1'b0);
        drain(300);
        eng_d0 = 50;
        eng_d1 = 50;
        reinit_from_idle();
        drain(50);

        // asynchronous reset in CONFIG
        start_run(300, 300, 1'b0);
        tick_to(400);
        #2;
        mon_en = 1'b0;
        rst_n  = 1'b0;
        #1;
        check_vec("async_reset", mk(1, 0, 0, 0, 0, 0, 0));
        exp_q.delete();
        @(negedge clk);
        check_vec("async_reset_held", mk(1, 0, 0, 0, 0, 0, 0));
        eng_att = 0;
        prev    = mk(1, 0, 0, 0, 0, 0, 0);
        rst_n   = 1'b1;
        base    = cyc;
        gen_seq(0, 0);
        mon_en = 1'b1;
        drain(30);

        // randomized engine latency, optional ignored request, optional reinit
        for (int i = 0; i < 4; i++) begin
            d = $urandom_range(0, 400);
            start_run(d, d, 1'b0);
            if ($urandom_range(0, 1) == 1) begin
                pe = $urandom_range(1, 260 + d);
                tick_to(pe - 1);
                pulse_reinit();
            end
            drain(20);
            if ($urandom_range(0, 1) == 1) begin
                reinit_from_idle();
                drain(20);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
